// File: rtl/pchri03_param_counter.sv
// Modulo counter with prescaler, up/down, load/clear, one-shot FSM, tc pulse and sticky wrap flag.
// Outputs are registered (one-edge latency, no input-to-output paths); optional snapshot port under PCHRI03_COUNTER_CAPTURE_EN.
module pchri03_param_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_i,
  input  logic             oneshot_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrapped_o,
  output logic             running_o
`ifdef PCHRI03_COUNTER_CAPTURE_EN
  ,
  input  logic             capture_i,
  output logic [WIDTH-1:0] cap_val_o
`endif
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;
  logic             running_q, running_d;

  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] load_clamped;

  assign tick    = (state_q == ST_RUN) && ena_i && (psc_q == PSC_MAX);
  assign at_term = up_i ? (count_q == CNT_MAX) : (count_q == '0);

  always_comb begin
    count_step = count_q;
    if (up_i) begin
      count_step = at_term ? '0 : count_q + 1'b1;
    end else begin
      count_step = at_term ? CNT_MAX : count_q - 1'b1;
    end
  end

  assign load_clamped = (load_val_i > CNT_MAX) ? CNT_MAX : load_val_i;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    psc_d     = psc_q;
    tc_d      = 1'b0;
    wrapped_d = wrapped_q;

    if (clr_i) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      psc_d     = '0;
      wrapped_d = 1'b0;
    end else if (load_i) begin
      // A tick landing on a load edge is dropped along with its tc.
      count_d = load_clamped;
      psc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
            psc_d   = '0;
          end
        end
        ST_DONE: begin
          if (start_i) begin
            state_d = ST_RUN;
            psc_d   = '0;
            count_d = up_i ? '0 : CNT_MAX;
          end
        end
        ST_RUN: begin
          if (ena_i) begin
            if (tick) begin
              psc_d = '0;
              tc_d  = at_term;
              if (at_term && oneshot_i) begin
                state_d = ST_DONE;
              end else begin
                count_d = count_step;
              end
            end else begin
              psc_d = psc_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    wrapped_d = wrapped_d | tc_d;
  end

  assign running_d = (state_d == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      psc_q     <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      psc_q     <= psc_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
      running_q <= running_d;
    end
  end

  assign count_o   = count_q;
  assign tc_o      = tc_q;
  assign wrapped_o = wrapped_q;
  assign running_o = running_q;

`ifdef PCHRI03_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q;

  // Snapshot takes the pre-edge count and is independent of clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_val_q <= '0;
    end else if (capture_i) begin
      cap_val_q <= count_q;
    end
  end

  assign cap_val_o = cap_val_q;
`endif

endmodule

// File: tb/tb_pchri03_param_counter.sv
// Directed bench: four counter configurations share stimulus; each scenario checks the instance it targets.
module tb_pchri03_param_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, clr, load, up, oneshot, start;
  logic [7:0] load_val;
  logic [7:0] cnt [4];
  logic       tc  [4];
  logic       wrp [4];
  logic       run [4];
`ifdef PCHRI03_COUNTER_CAPTURE_EN
  logic       capture;
  logic [7:0] cap [4];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // instance 0: 256/1, 1: 10/3, 2: 4/1, 3: 100/1
  function automatic int mod_of(int g);
    case (g)
      0: return 256;
      1: return 10;
      2: return 4;
      default: return 100;
    endcase
  endfunction

  function automatic int psc_of(int g);
    return (g == 1) ? 3 : 1;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pchri03_param_counter #(
      .WIDTH   (8),
      .MODULUS (mod_of(g)),
      .PRESCALE(psc_of(g))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena_i     (ena),
      .clr_i     (clr),
      .load_i    (load),
      .load_val_i(load_val),
      .up_i      (up),
      .oneshot_i (oneshot),
      .start_i   (start),
      .count_o   (cnt[g]),
      .tc_o      (tc[g]),
      .wrapped_o (wrp[g]),
      .running_o (run[g])
`ifdef PCHRI03_COUNTER_CAPTURE_EN
      ,
      .capture_i (capture),
      .cap_val_o (cap[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0;
    up = 1'b1; oneshot = 1'b0; start = 1'b0;
`ifdef PCHRI03_COUNTER_CAPTURE_EN
    capture = 1'b0;
`endif
    #12;
    chk("rst_count", cnt[0], 0);
    chk("rst_tc", tc[0], 0);
    chk("rst_wrapped", wrp[0], 0);
    chk("rst_running", run[0], 0);
`ifdef PCHRI03_COUNTER_CAPTURE_EN
    chk("rst_cap", cap[0], 0);
`endif
    rst_n = 1'b1;

    // Full free-running up lap at MODULUS=256
    start = 1'b1; ena = 1'b1;
    step();
    start = 1'b0;
    chk("t1_running", run[0], 1);
    chk("t1_count0", cnt[0], 0);
    for (int i = 1; i < 256; i++) begin
      step();
      chk("t1_count", cnt[0], i);
      chk("t1_tc_low", tc[0], 0);
    end
    chk("t1_wrapped_pre", wrp[0], 0);
    step();
    chk("t1_wrap_count", cnt[0], 0);
    chk("t1_wrap_tc", tc[0], 1);
    chk("t1_wrapped", wrp[0], 1);
    step();
    chk("t1_after_count", cnt[0], 1);
    chk("t1_after_tc", tc[0], 0);
    chk("t1_sticky", wrp[0], 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_count", cnt[0], 0);
    chk("clr_wrapped", wrp[0], 0);
    chk("clr_running", run[0], 0);

    // MODULUS=10 PRESCALE=3 counting down
    up = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_start_count", cnt[1], 0);
    step();
    chk("t2_c1", cnt[1], 0);
    step();
    chk("t2_c2", cnt[1], 0);
    step();
    chk("t2_nine", cnt[1], 9);
    chk("t2_tc", tc[1], 1);
    chk("t2_wrapped", wrp[1], 1);
    step();
    chk("t2_hold9a", cnt[1], 9);
    chk("t2_tc_low", tc[1], 0);
    step();
    chk("t2_hold9b", cnt[1], 9);
    step();
    chk("t2_eight", cnt[1], 8);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_frozen", cnt[1], 8);
    end
    ena = 1'b1;
    step();
    step();
    chk("t2_resume_hold", cnt[1], 8);
    step();
    chk("t2_seven", cnt[1], 7);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // One-shot, MODULUS=4, up
    up = 1'b1; oneshot = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_running", run[2], 1);
    chk("t3_c0", cnt[2], 0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t3_count", cnt[2], i);
      chk("t3_tc_low", tc[2], 0);
    end
    step();
    chk("t3_hold3", cnt[2], 3);
    chk("t3_tc", tc[2], 1);
    chk("t3_done", run[2], 0);
    step();
    chk("t3_hold3b", cnt[2], 3);
    chk("t3_tc_once", tc[2], 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_restart", cnt[2], 0);
    chk("t3_rerun", run[2], 1);
    step();
    chk("t3_restart_step", cnt[2], 1);
    oneshot = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;

    // Load clamp against a same-edge tick, then clr beats load
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_c0", cnt[3], 0);
    load = 1'b1; load_val = 8'd200;
    step();
    load = 1'b0;
    chk("t4_clamp", cnt[3], 99);
    chk("t4_no_tc", tc[3], 0);
    chk("t4_still_run", run[3], 1);
    step();
    chk("t4_wrap", cnt[3], 0);
    chk("t4_tc", tc[3], 1);
    clr = 1'b1; load = 1'b1; load_val = 8'd50;
    step();
    clr = 1'b0; load = 1'b0;
    chk("t4_clrload_count", cnt[3], 0);
    chk("t4_clrload_idle", run[3], 0);
    chk("t4_clrload_wrp", wrp[3], 0);

    // Async reset mid-run
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t5_count5", cnt[0], 5);
    chk("t5_m4_wrapped", wrp[2], 1);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_count", cnt[0], 0);
    chk("t5_rst_running", run[0], 0);
    chk("t5_rst_wrapped", wrp[2], 0);
    chk("t5_rst_tc", tc[2], 0);
    #2;
    rst_n = 1'b1;

`ifdef PCHRI03_COUNTER_CAPTURE_EN
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t6_count7", cnt[0], 7);
    capture = 1'b1;
    step();
    capture = 1'b0;
    chk("t6_count8", cnt[0], 8);
    chk("t6_cap", cap[0], 7);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_cap_after_clr", cap[0], 7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
